// File: rtl/reg_write_arbiter.sv
// Register-file write arbiter: clears x1..x(N-1) after reset, then
// arbitrates ALU (A) and load (B) writebacks onto one registered write port.
module reg_write_arbiter #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      i_Clock,
    input  logic                      i_Reset,

    input  logic                      i_A_Valid,
    input  logic [REG_ADDR_WIDTH-1:0] i_A_Addr,
    input  logic [XLEN-1:0]           i_A_Data,
    output logic                      o_A_Ready,

    input  logic                      i_B_Valid,
    input  logic [REG_ADDR_WIDTH-1:0] i_B_Addr,
    input  logic [XLEN-1:0]           i_B_Data,
    output logic                      o_B_Ready,

    output logic                      o_Write_Enable,
    output logic [REG_ADDR_WIDTH-1:0] o_Write_Addr,
    output logic [XLEN-1:0]           o_Write_Data,

    output logic                      o_Init_Done
);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_e;

    localparam logic GRANT_A = 1'b0;
    localparam logic GRANT_B = 1'b1;

    localparam logic [REG_ADDR_WIDTH-1:0] ADDR_ZERO = '0;
    localparam logic [REG_ADDR_WIDTH-1:0] ADDR_ONE  =
        {{(REG_ADDR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [REG_ADDR_WIDTH-1:0] ADDR_LAST = '1;

    state_e                      state_q, state_d;
    logic [REG_ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic                        last_grant_q, last_grant_d;

    logic                        wr_en_q, wr_en_d;
    logic [REG_ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [XLEN-1:0]             wr_data_q, wr_data_d;

    logic                        clear_issue;
    logic                        run_en;
    logic                        init_done;
    logic                        grant_a;
    logic                        grant_b;

    // State register; reset always restarts the clear sequence.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= S_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Leave CLEAR once the highest register has been issued.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_CLEAR: begin
                if (cnt_q == ADDR_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                state_d = S_RUN;
            end
            default: begin
                state_d = S_CLEAR;
            end
        endcase
    end

    // Per-state controls: clear writes in CLEAR, arbitration in RUN.
    always_comb begin
        clear_issue = 1'b0;
        run_en      = 1'b0;
        init_done   = 1'b0;
        unique case (state_q)
            S_CLEAR: begin
                clear_issue = 1'b1;
            end
            S_RUN: begin
                run_en    = 1'b1;
                init_done = 1'b1;
            end
            default: begin
                clear_issue = 1'b0;
            end
        endcase
    end

    // Clear address counter, starting at x1 so x0 is never touched.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_issue) begin
            cnt_d = cnt_q + ADDR_ONE;
        end
    end

    // Counter register.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            cnt_q <= ADDR_ONE;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Round-robin grant: a lone requester wins, a tie goes to the one
    // that did not win last time.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (run_en) begin
            if (i_A_Valid && i_B_Valid) begin
                grant_a = (last_grant_q == GRANT_B);
                grant_b = (last_grant_q == GRANT_A);
            end else begin
                grant_a = i_A_Valid;
                grant_b = i_B_Valid;
            end
        end
    end

    // Remember the winner of every handshake.
    always_comb begin
        last_grant_d = last_grant_q;
        if (grant_a) begin
            last_grant_d = GRANT_A;
        end else if (grant_b) begin
            last_grant_d = GRANT_B;
        end
    end

    // Last-grant register; B after reset so A wins the first tie.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            last_grant_q <= GRANT_B;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    // Next write-port contents; x0 writes are consumed but suppressed.
    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (clear_issue) begin
            wr_en_d   = 1'b1;
            wr_addr_d = cnt_q;
            wr_data_d = '0;
        end else if (grant_a) begin
            wr_en_d   = (i_A_Addr != ADDR_ZERO);
            wr_addr_d = i_A_Addr;
            wr_data_d = i_A_Data;
        end else if (grant_b) begin
            wr_en_d   = (i_B_Addr != ADDR_ZERO);
            wr_addr_d = i_B_Addr;
            wr_data_d = i_B_Data;
        end
    end

    // Write-port register; reset drops anything accepted this cycle.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign o_A_Ready      = grant_a;
    assign o_B_Ready      = grant_b;
    assign o_Write_Enable = wr_en_q;
    assign o_Write_Addr   = wr_addr_q;
    assign o_Write_Data   = wr_data_q;
    assign o_Init_Done    = init_done;

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the data width of the register write port.
REQ-002 The block SHALL have parameter REG_ADDR_WIDTH, default 5, meaning the register address width (32 registers).
REQ-003 The block SHALL have port i_Clock, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port i_Reset, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have ports i_A_Valid (input, 1), i_A_Addr (input, REG_ADDR_WIDTH), i_A_Data (input, XLEN) and o_A_Ready (output, 1), forming requester A (ALU writeback).
REQ-006 The block SHALL have ports i_B_Valid (input, 1), i_B_Addr (input, REG_ADDR_WIDTH), i_B_Data (input, XLEN) and o_B_Ready (output, 1), forming requester B (load writeback).
REQ-007 The block SHALL have ports o_Write_Enable (output, 1), o_Write_Addr (output, REG_ADDR_WIDTH) and o_Write_Data (output, XLEN), driving the register file write port.
REQ-008 The block SHALL have port o_Init_Done, output, 1 bit, high once the register clear sequence has completed.

Function
REQ-009 The block SHALL implement a two-state FSM, CLEAR and RUN.
REQ-010 The block SHALL enter CLEAR on reset with its clear counter set to 1.
REQ-011 In CLEAR, the block SHALL issue one registered write per cycle: address = counter, data = 0, enable = 1, then increment the counter.
REQ-012 CLEAR SHALL write addresses 1..31 only (31 writes), then the block SHALL transition to RUN; address 0 is never written.
REQ-013 o_Init_Done SHALL be 0 in CLEAR and 1 in RUN.
REQ-014 In CLEAR, o_A_Ready and o_B_Ready SHALL be 0.
REQ-015 In RUN, readies SHALL be combinational: grant A or B per REQ-016..REQ-018; the ungranted requester and any non-valid requester see ready = 0.
REQ-016 A handshake SHALL occur when valid & ready in the same cycle; a requester SHALL hold addr and data stable while valid and not ready.
REQ-017 When only one requester is valid, the block SHALL grant it.
REQ-018 When both requesters are valid, the block SHALL grant the one not recorded in last_grant.
REQ-019 last_grant SHALL update to the granted requester on every handshake.
REQ-020 last_grant SHALL reset to B, so that A wins the first contested cycle.
REQ-021 An accepted write SHALL appear on o_Write_* exactly one cycle after the handshake, with enable high for exactly one cycle; throughput is one write per cycle.
REQ-022 An accepted write to address 0 SHALL be consumed (ready asserted normally) but SHALL produce o_Write_Enable = 0.
REQ-023 When no handshake occurs, o_Write_Enable SHALL be 0 next cycle, and o_Write_Addr and o_Write_Data SHALL hold their previous values.
REQ-024 When both requesters target the same address, only the granted one SHALL be written that cycle; the other SHALL write on a later grant (last writer wins in grant order).
REQ-025 Each requester SHALL be granted within 2 cycles of asserting valid (starvation-free).

Reset
REQ-026 When i_Reset is high at a clock edge, next-cycle outputs SHALL be: o_Write_Enable = 0, o_Write_Addr = 0, o_Write_Data = 0, o_Init_Done = 0, o_A_Ready = 0, o_B_Ready = 0, state = CLEAR, counter = 1, last_grant = B.
REQ-027 Reset asserted mid-RUN SHALL drop any write accepted in the same cycle (no write emitted) and SHALL restart the full CLEAR sequence.
REQ-028 Reset asserted mid-CLEAR SHALL restart CLEAR from address 1.
REQ-029 While i_Reset is held, readies SHALL stay 0 and no write SHALL be issued.

Verification
REQ-030 Bench: release reset -> 31 consecutive cycles of o_Write_Enable = 1 with addresses 1..31 and data 0, then o_Init_Done = 1 and no further writes.
REQ-031 Bench: in RUN, A valid with addr 5, data 0xDEADBEEF, B idle -> o_A_Ready = 1 the same cycle; next cycle o_Write_Enable = 1, addr 5, data 0xDEADBEEF.
REQ-032 Bench: A and B both valid continuously (A: addr 3, data 0x11; B: addr 4, data 0x22) -> grants A, B, A, B; writes alternate 3/0x11 and 4/0x22 every cycle.
REQ-033 Bench: B valid with addr 0, data 0xFFFFFFFF -> o_B_Ready = 1, and o_Write_Enable = 0 the following cycle.
REQ-034 Bench: A handshake (addr 7) in the same cycle i_Reset = 1 -> no write to addr 7; the next cycle shows o_Write_Enable = 0, and CLEAR restarts at addr 1.
REQ-035 Bench: A and B both valid targeting addr 9 (A data 0x1, B data 0x2) -> write 0x1 then 0x2 on consecutive cycles; final value 0x2.
